// File: rtl/spdif_tx_gen.sv
// ============================================================================
// Module   : spdif_tx_gen
// Brief    : S/PDIF (IEC 60958) transmitter with a stereo-pair FIFO, channel
//            status generation, mute/underrun handling and BMC line output.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spdif_tx_gen #(
    parameter int         SAMPLE_W   = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CS_RATE    = 4'b0100,
    parameter logic [3:0] CS_WLEN    = 4'b0100
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          bit_en_i,
    input  logic [SAMPLE_W-1:0]           sample_l_i,
    input  logic [SAMPLE_W-1:0]           sample_r_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    input  logic                          mute_i,
    output logic                          spdif_o,
    output logic                          underrun_o,
    output logic                          block_start_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int               c_aw          = $clog2(FIFO_DEPTH);
    localparam int               c_lw          = c_aw + 1;
    localparam logic [c_lw-1:0]  c_depth       = c_lw'(FIFO_DEPTH);
    localparam logic [7:0]       c_pre_b       = 8'b00010111;
    localparam logic [7:0]       c_pre_m       = 8'b01000111;
    localparam logic [7:0]       c_pre_w       = 8'b00100111;
    // Silent subframe: validity (slot 28) set, so parity (slot 31) is set too.
    localparam logic [31:0]      c_reset_slots = 32'h9000_0000;

    logic [SAMPLE_W-1:0] r_mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] r_mem_r [FIFO_DEPTH];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_lw-1:0]     r_level;

    logic [5:0]          r_hb;
    logic [8:0]          r_sf;
    logic [7:0]          r_pre;
    logic [31:0]         r_slots;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic                r_buf_v;
    logic                r_spdif;
    logic                r_underrun;
    logic                r_block;

    logic                w_push;
    logic                w_pop;
    logic                w_latch;
    logic                w_left;
    logic                w_empty;
    logic                w_underrun;
    logic [8:0]          w_sf_nxt;
    logic [7:0]          w_cs_idx;
    logic                w_cs;
    logic [SAMPLE_W-1:0] w_audio;
    logic                w_valid;
    logic [SAMPLE_W-1:0] w_buf_r_nxt;
    logic                w_buf_v_nxt;
    logic [31:0]         w_slots;
    logic [7:0]          w_pre;
    logic                w_line_nxt;

    assign sample_ready_o = (r_level < c_depth);
    assign fifo_level_o   = r_level;
    assign spdif_o        = r_spdif;
    assign underrun_o     = r_underrun;
    assign block_start_o  = r_block;

    assign w_push     = sample_valid_i && sample_ready_o;
    assign w_latch    = bit_en_i && (r_hb == 6'd63);
    assign w_sf_nxt   = (r_sf == 9'd383) ? 9'd0 : r_sf + 9'd1;
    assign w_left     = ~w_sf_nxt[0];
    assign w_empty    = (r_level == '0);
    assign w_pop      = w_latch && w_left && !w_empty;
    assign w_underrun = w_latch && w_left && w_empty;

    // Channel-status word is sparse: bit 2, rate nibble at 24..27, length at 32..35.
    assign w_cs_idx = w_sf_nxt[8:1];
    assign w_cs     = (w_cs_idx == 8'd2)
                    | ((w_cs_idx[7:2] == 6'd6) & CS_RATE[w_cs_idx[1:0]])
                    | ((w_cs_idx[7:2] == 6'd8) & CS_WLEN[w_cs_idx[1:0]]);

    always_comb begin
        w_audio     = '0;
        w_valid     = 1'b0;
        w_buf_r_nxt = r_buf_r;
        w_buf_v_nxt = r_buf_v;
        if (w_left) begin
            if (w_empty) begin
                w_valid     = 1'b1;
                w_buf_r_nxt = '0;
                w_buf_v_nxt = 1'b1;
            end else if (mute_i) begin
                w_buf_r_nxt = '0;
                w_buf_v_nxt = 1'b0;
            end else begin
                w_audio     = r_mem_l[r_rd_ptr];
                w_buf_r_nxt = r_mem_r[r_rd_ptr];
                w_buf_v_nxt = 1'b0;
            end
        end else begin
            w_audio = r_buf_r;
            w_valid = r_buf_v;
        end
    end

    always_comb begin
        w_slots                  = '0;
        w_slots[27 -: SAMPLE_W]  = w_audio;
        w_slots[28]              = w_valid;
        w_slots[30]              = w_cs;
        w_slots[31]              = ^{w_cs, w_valid, w_audio};
    end

    assign w_pre = (w_sf_nxt == 9'd0) ? c_pre_b : (w_left ? c_pre_m : c_pre_w);

    // Preamble half-bits go out raw; data slots are biphase-mark coded from the current level.
    always_comb begin
        w_line_nxt = r_spdif;
        if (r_hb < 6'd8) begin
            w_line_nxt = r_pre[r_hb[2:0]];
        end else if (!r_hb[0]) begin
            w_line_nxt = ~r_spdif;
        end else begin
            w_line_nxt = r_spdif ^ r_slots[r_hb[5:1]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_l[r_wr_ptr] <= sample_l_i;
            r_mem_r[r_wr_ptr] <= sample_r_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hb       <= '0;
            r_sf       <= '0;
            r_spdif    <= 1'b0;
            r_underrun <= 1'b0;
            r_block    <= 1'b0;
            r_pre      <= c_pre_b;
            r_slots    <= c_reset_slots;
            r_buf_r    <= '0;
            r_buf_v    <= 1'b1;
        end else begin
            r_underrun <= w_underrun;
            r_block    <= w_latch && (w_sf_nxt == 9'd0);
            if (bit_en_i) begin
                r_hb    <= r_hb + 6'd1;
                r_spdif <= w_line_nxt;
            end
            if (w_latch) begin
                r_sf    <= w_sf_nxt;
                r_pre   <= w_pre;
                r_slots <= w_slots;
                r_buf_r <= w_buf_r_nxt;
                r_buf_v <= w_buf_v_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spdif_tx_gen.sv
// ============================================================================
// Module   : tb_spdif_tx_gen
// Brief    : Scoreboard bench for spdif_tx_gen; decodes the BMC line per subframe.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spdif_tx_gen;

    localparam int SW    = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_en;
    logic [SW-1:0] sample_l;
    logic [SW-1:0] sample_r;
    logic          sample_valid;
    logic          sample_ready;
    logic          mute;
    logic          spdif;
    logic          underrun;
    logic          block_start;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    spdif_tx_gen #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .CS_RATE    (4'b0100),
        .CS_WLEN    (4'b0100)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bit_en_i       (bit_en),
        .sample_l_i     (sample_l),
        .sample_r_i     (sample_r),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .mute_i         (mute),
        .spdif_o        (spdif),
        .underrun_o     (underrun),
        .block_start_o  (block_start),
        .fifo_level_o   (fifo_level)
    );

    typedef struct packed {
        logic [7:0]  pre;
        logic [23:0] aud;
        logic        v;
        logic        c;
    } sub_t;

    sub_t exp_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   exp_sf     = 0;
    int   n_sub_seen = 0;
    int   n_underrun = 0;
    int   n_block    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // CS_RATE=0100 sets word bit 26, CS_WLEN=0100 sets bit 34, plus fixed bit 2.
    function automatic logic cs_exp(input int sf);
        int f;
        f = (sf % 384) / 2;
        return (f == 2) || (f == 26) || (f == 34);
    endfunction

    function automatic logic [7:0] pre_exp(input int sf);
        int s;
        s = sf % 384;
        if (s == 0)          return 8'b00010111;
        else if (s % 2 == 0) return 8'b01000111;
        else                 return 8'b00100111;
    endfunction

    task automatic expect_frame(input logic [23:0] l, input logic [23:0] r, input logic v);
        sub_t e;
        e.pre = pre_exp(exp_sf); e.aud = l; e.v = v; e.c = cs_exp(exp_sf);
        exp_q.push_back(e);
        exp_sf++;
        e.pre = pre_exp(exp_sf); e.aud = r; e.v = v; e.c = cs_exp(exp_sf);
        exp_q.push_back(e);
        exp_sf++;
    endtask

    task automatic strobe(input logic push, input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        bit_en = 1'b1;
        if (push) begin
            sample_valid = 1'b1;
            sample_l     = l;
            sample_r     = r;
        end
        @(negedge clk);
        bit_en       = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic strobes(input int n);
        repeat (n) strobe(1'b0, 24'h0, 24'h0);
    endtask

    task automatic run_sub(input int n);
        strobes(n * 64);
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_l     = l;
        sample_r     = r;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (underrun)    n_underrun++;
        if (block_start) n_block++;
    end

    // Monitor: collect 64 half-bits per subframe and decode the line independently.
    initial begin : monitor
        logic [63:0] hv;
        logic [31:0] d;
        logic        en;
        logic        lvl;
        logic        bmc_ok;
        sub_t        e;
        forever begin
            for (int k = 0; k < 64; k++) begin
                en = 1'b0;
                while (!en) begin
                    @(posedge clk);
                    en = bit_en;
                    @(negedge clk);
                end
                hv[k] = spdif;
            end
            lvl    = hv[7];
            bmc_ok = 1'b1;
            d      = '0;
            for (int s = 4; s < 32; s++) begin
                if (hv[2*s] == lvl) bmc_ok = 1'b0;
                d[s] = hv[2*s] ^ hv[2*s+1];
                lvl  = hv[2*s+1];
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sf%0d: no expected subframe queued", n_sub_seen);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("sf%0d preamble", n_sub_seen), {24'h0, hv[7:0]}, {24'h0, e.pre});
                check($sformatf("sf%0d audio", n_sub_seen), {8'h0, d[27:4]}, {8'h0, e.aud});
                check($sformatf("sf%0d validity", n_sub_seen), {31'h0, d[28]}, {31'h0, e.v});
                check($sformatf("sf%0d user", n_sub_seen), {31'h0, d[29]}, 32'h0);
                check($sformatf("sf%0d chan_status", n_sub_seen), {31'h0, d[30]}, {31'h0, e.c});
                check($sformatf("sf%0d parity_even", n_sub_seen), {31'h0, ^d[31:4]}, 32'h0);
                check($sformatf("sf%0d bmc_transitions", n_sub_seen), {31'h0, bmc_ok}, 32'h1);
                check($sformatf("sf%0d end_level", n_sub_seen), {31'h0, lvl}, 32'h0);
            end
            n_sub_seen++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n        = 1'b0;
        bit_en       = 1'b0;
        sample_valid = 1'b0;
        mute         = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        repeat (3) @(negedge clk);
        check("reset spdif_o", {31'h0, spdif}, 32'h0);
        check("reset underrun_o", {31'h0, underrun}, 32'h0);
        check("reset block_start_o", {31'h0, block_start}, 32'h0);
        check("reset fifo_level_o", {29'h0, fifo_level}, 32'h0);
        check("reset sample_ready_o", {31'h0, sample_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the FIFO with no strobes, then try one refused push.
        push_pair(24'h800001, 24'h7FFFFF);
        push_pair(24'h123456, 24'hABCDEF);
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        check("full fifo_level_o", {29'h0, fifo_level}, 32'd4);
        check("full sample_ready_o", {31'h0, sample_ready}, 32'h0);
        push_pair(24'hDEAD00, 24'hBEEF00);
        check("refused push level", {29'h0, fifo_level}, 32'd4);

        expect_frame(24'h0, 24'h0, 1'b1);
        expect_frame(24'h800001, 24'h7FFFFF, 1'b0);
        expect_frame(24'h123456, 24'hABCDEF, 1'b0);
        run_sub(2);
        check("level after first pop", {29'h0, fifo_level}, 32'd3);
        run_sub(1);
        strobes(63);
        strobe(1'b1, 24'hFEDCBA, 24'h000001);
        check("push+pop level", {29'h0, fifo_level}, 32'd3);

        run_sub(1);
        mute = 1'b1;
        expect_frame(24'h0, 24'h0, 1'b0);
        expect_frame(24'h0, 24'h0, 1'b0);
        run_sub(1);
        check("mute pop level 2", {29'h0, fifo_level}, 32'd2);
        run_sub(2);
        check("mute pop level 1", {29'h0, fifo_level}, 32'd1);
        mute = 1'b0;
        expect_frame(24'hFEDCBA, 24'h000001, 1'b0);
        run_sub(2);
        check("drained level", {29'h0, fifo_level}, 32'd0);

        expect_frame(24'h0, 24'h0, 1'b1);
        run_sub(1);
        strobes(63);
        strobe(1'b0, 24'h0, 24'h0);
        check("underrun pulse", {31'h0, underrun}, 32'h1);
        @(negedge clk);
        check("underrun pulse width", {31'h0, underrun}, 32'h0);
        push_pair(24'h5A5A5A, 24'hA5A5A5);
        check("level after late push", {29'h0, fifo_level}, 32'd1);
        expect_frame(24'h5A5A5A, 24'hA5A5A5, 1'b0);
        run_sub(4);

        // Remainder of the block plus first frame of the next block, all underrun.
        for (int f = 0; f < 185; f++) expect_frame(24'h0, 24'h0, 1'b1);
        run_sub(367);
        strobes(63);
        check("no block_start before wrap", {31'h0, block_start}, 32'h0);
        strobe(1'b0, 24'h0, 24'h0);
        check("block_start at wrap", {31'h0, block_start}, 32'h1);
        run_sub(2);
        repeat (4) @(negedge clk);

        check("subframes seen", n_sub_seen, 32'd386);
        check("expect queue drained", exp_q.size(), 32'd0);
        check("underrun pulse count", n_underrun, 32'd187);
        check("block_start pulse count", n_block, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
